// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse-width measurement block.
package pulse_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_IN_PULSE
   } state_t;

   localparam int DEF_DATA_WIDTH = 64;

   function automatic int log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pulse_meas_lsb_find.sv
// Lowest-set-bit priority encoder: index of the least significant 1 and a found flag.
module lsb_find import pulse_pkg::*; #(
   parameter int W  = DEF_DATA_WIDTH,
   parameter int IW = log2(W)
) (
   input  logic [W-1:0]  i_vec,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = IW'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pulse_meas.sv
// Measures high-time and start position of pulses in a parallel bit stream, one word per valid cycle.
module pulse_meas import pulse_pkg::*; #(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int CNT_W      = 16,
   parameter  int WCNT_W     = 32,
   localparam int IDX_W      = log2(DATA_WIDTH),
   localparam int TS_W       = WCNT_W + IDX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_done,
   output logic [CNT_W-1:0]      o_width,
   output logic [TS_W-1:0]       o_start,
   output logic                  o_sat,
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int SUM_W = CNT_W + IDX_W + 2;
   localparam logic [SUM_W-1:0]      MAX_W = SUM_W'({CNT_W{1'b1}});
   localparam logic [DATA_WIDTH-1:0] ONES  = '1;

   state_t              r_state;
   logic                r_prev;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [CNT_W-1:0]    r_acc;
   logic                r_sat;
   logic [TS_W-1:0]     r_start;

   logic [DATA_WIDTH-1:0] w_ext, w_rise, w_fall, w_fall_m, w_above_r, w_above_f;
   logic [IDX_W-1:0]      w_r_idx, w_f_idx;
   logic                  w_r_found, w_f_found, w_in, w_complete, w_err, w_over, w_sat;
   logic [SUM_W-1:0]      w_base, w_add, w_sum;
   logic [CNT_W-1:0]      w_width;
   logic [TS_W-1:0]       w_start_now;

   // Bit i of w_ext is the sample immediately preceding i_data[i].
   assign w_ext  = {i_data[DATA_WIDTH-2:0], r_prev};
   assign w_rise = i_data & ~w_ext;
   assign w_fall = ~i_data & w_ext;
   assign w_in   = (r_state == ST_IN_PULSE);

   lsb_find #(.W(DATA_WIDTH), .IW(IDX_W)) u_rise_find (
      .i_vec   (w_rise),
      .o_idx   (w_r_idx),
      .o_found (w_r_found)
   );

   // When idle, only a fall after the new rise can close the pulse.
   assign w_above_r = (ONES << w_r_idx) << 1;
   assign w_fall_m  = w_in ? w_fall : (w_fall & w_above_r);

   lsb_find #(.W(DATA_WIDTH), .IW(IDX_W)) u_fall_find (
      .i_vec   (w_fall_m),
      .o_idx   (w_f_idx),
      .o_found (w_f_found)
   );

   assign w_complete  = w_f_found && (w_in || w_r_found);
   assign w_above_f   = (ONES << w_f_idx) << 1;
   assign w_err       = w_complete && (|(w_rise & w_above_f));
   assign w_start_now = {r_wcnt, w_r_idx};

   always_comb begin
      w_add = '0;
      if (w_in)
         w_add = w_f_found ? SUM_W'(w_f_idx) : SUM_W'(DATA_WIDTH);
      else if (w_f_found)
         w_add = SUM_W'(w_f_idx) - SUM_W'(w_r_idx);
      else
         w_add = SUM_W'(DATA_WIDTH) - SUM_W'(w_r_idx);
   end

   assign w_base  = w_in ? SUM_W'(r_acc) : '0;
   assign w_sum   = w_base + w_add;
   assign w_over  = (w_sum > MAX_W);
   assign w_width = w_over ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
   assign w_sat   = (w_in & r_sat) | w_over;
   assign o_busy  = w_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_prev  <= 1'b0;
         r_wcnt  <= '0;
         r_acc   <= '0;
         r_sat   <= 1'b0;
         r_start <= '0;
         o_done  <= 1'b0;
         o_width <= '0;
         o_start <= '0;
         o_sat   <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_valid) begin
            r_prev <= i_data[DATA_WIDTH-1];
            r_wcnt <= r_wcnt + WCNT_W'(1);
            if (w_complete) begin
               o_done  <= 1'b1;
               o_width <= w_width;
               o_sat   <= w_sat;
               o_start <= w_in ? r_start : w_start_now;
               r_state <= ST_IDLE;
               r_acc   <= '0;
               if (w_err) o_err <= 1'b1;
            end else if (w_in || w_r_found) begin
               r_acc   <= w_width;
               r_sat   <= w_sat;
               r_state <= ST_IN_PULSE;
               if (!w_in) r_start <= w_start_now;
            end
         end
      end
   end

endmodule
